// File: rtl/velocity_estimator.sv
// velocity_estimator: position change over windows of 2^k accepted samples, emitted as a saturated AXI-Stream word
module velocity_estimator #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int MAX_LOG_COUNT    = 16
) (
  input  logic                               SYS_aclk,
  input  logic                               SYS_areset,
  input  logic [4:0]                         CFG_log_count,
  input  logic                               STAT_clear,
  input  logic                               S_AXIS_tvalid,
  input  logic signed [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                               M_AXIS_tvalid,
  input  logic                               M_AXIS_tready,
  output logic signed [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                               STAT_overflow
);
  localparam int W  = AXIS_TDATA_WIDTH;
  localparam int CW = MAX_LOG_COUNT;
  localparam logic [CW-1:0] ONES = '1;
  typedef enum logic {INIT, RUN} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    ref_q, ref_d;
  logic [4:0]      k_q, k_new;
  logic            k_ok_q;
  logic            tvalid_q, tvalid_d;
  logic [W-1:0]    tdata_q, tdata_d;
  logic            ovf_q, ovf_d;
  logic            cfg_change, result, drop;
  logic [CW-1:0]   last_cnt;
  logic [W:0]      diff;
  logic [W-1:0]    sat;
  assign k_new      = (CFG_log_count > 5'(CW)) ? 5'(CW) : CFG_log_count;
  // the very first clock after reset only latches k; it is not a config change
  assign cfg_change = k_ok_q && (k_new != k_q);
  assign last_cnt   = ONES >> (5'(CW) - k_q);
  assign diff       = {S_AXIS_tdata[W-1], S_AXIS_tdata} - {ref_q[W-1], ref_q};
  assign sat        = (diff[W] != diff[W-1]) ? {diff[W], {(W-1){~diff[W]}}} : diff[W-1:0];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    result  = 1'b0;
    if (cfg_change) begin
      state_d = INIT;
      cnt_d   = '0;
    end else if (S_AXIS_tvalid) begin
      if (state_q == INIT) begin
        state_d = RUN;
        ref_d   = S_AXIS_tdata;
        cnt_d   = '0;
      end else if (cnt_q == last_cnt) begin
        result = 1'b1;
        ref_d  = S_AXIS_tdata;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    drop     = result && tvalid_q && !M_AXIS_tready;
    tvalid_d = result || (tvalid_q && !M_AXIS_tready);
    tdata_d  = (result && !drop) ? sat : tdata_q;
    ovf_d    = drop || (ovf_q && !STAT_clear);
  end
  always_ff @(posedge SYS_aclk or posedge SYS_areset) begin
    if (SYS_areset) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      ref_q    <= '0;
      k_q      <= '0;
      k_ok_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      k_q      <= k_new;
      k_ok_q   <= 1'b1;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      ovf_q    <= ovf_d;
    end
  end
  assign M_AXIS_tvalid = tvalid_q;
  assign M_AXIS_tdata  = tdata_q;
  assign STAT_overflow = ovf_q;
endmodule
